// File: rtl/grid_mover_pkg.sv
// Shared types for the tile-grid mover: headings, controller states and target-tile math.
// Combinational helpers only; no state, no handshake.
package grid_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_W  = 3'd1,
        ST_WAIT_W = 3'd2,
        ST_REQ_C  = 3'd3,
        ST_WAIT_C = 3'd4
    } state_t;

    localparam int RC_W = 16;

    typedef struct packed {
        logic [RC_W-1:0] row;
        logic [RC_W-1:0] col;
        logic            off;
    } rc_t;

    // Neighbour tile of (row, col) in heading d; off flags a step leaving the grid.
    function automatic rc_t next_rowcol(input logic [RC_W-1:0] row,
                                        input logic [RC_W-1:0] col,
                                        input dir_t            d,
                                        input int              cols,
                                        input int              rows,
                                        input bit              wrap);
        rc_t r;
        r.row = row;
        r.col = col;
        r.off = 1'b0;
        case (d)
            UP:      if (row == '0) r.off = 1'b1; else r.row = row - 1'b1;
            DOWN:    if (row == RC_W'(rows - 1)) r.off = 1'b1; else r.row = row + 1'b1;
            LEFT: begin
                if (col != '0)  r.col = col - 1'b1;
                else if (wrap)  r.col = RC_W'(cols - 1);
                else            r.off = 1'b1;
            end
            RIGHT: begin
                if (col != RC_W'(cols - 1)) r.col = col + 1'b1;
                else if (wrap)              r.col = '0;
                else                        r.off = 1'b1;
            end
            default: r.off = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/grid_mover_if.sv
// Wall-memory lookup channel: one-cycle request strobe, address held until the response strobe.
// Responder may take any number of cycles; requester waits indefinitely.
interface grid_mover_if #(parameter int IDX_W = 10);
    logic             wall_req;
    logic [IDX_W-1:0] wall_addr;
    logic             wall_valid;
    logic             wall_is_wall;

    modport master (output wall_req, output wall_addr, input wall_valid, input wall_is_wall);
    modport slave  (input wall_req, input wall_addr, output wall_valid, output wall_is_wall);
endinterface

// File: rtl/grid_mover_step_ticker.sv
// Free-running move-attempt pacer: tick on the terminal count of a 0..STEP_TICKS-1 counter.
// Tick is combinational from the count; counter freezes while enable is low.
module step_ticker #(
    parameter int STEP_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);
    localparam int              CNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_TICKS - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == LAST);
endmodule

// File: rtl/grid_mover.sv
// Sprite tile mover: buffers the requested turn, wall-checks one step per tick, falls back to heading.
// Tick->move is 3 cycles with a 1-cycle wall memory (5 on fallback); ticks arriving mid-lookup are dropped.
module grid_mover
    import grid_pkg::*;
#(
    parameter int COLS       = 28,
    parameter int ROWS       = 31,
    parameter int IDX_W      = $clog2(COLS * ROWS),
    parameter int STEP_TICKS = 4,
    parameter int WRAP_EN    = 1,
    parameter int START_IDX  = 658
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    grid_mover_if.master     wall,
    output logic [IDX_W-1:0] curr_block,
    output dir_t             dir,
    output logic             moved,
    output logic             blocked
);
    localparam logic [RC_W-1:0] START_ROW = RC_W'(START_IDX / COLS);
    localparam logic [RC_W-1:0] START_COL = RC_W'(START_IDX % COLS);

    state_t           state;
    dir_t             want_dir, snap, dir_in;
    logic [RC_W-1:0]  row_q, col_q, tgt_row, tgt_col;
    logic             tgt_off;
    logic [IDX_W-1:0] addr_q;
    logic             tick, take_move, try_fail;
    rc_t              nx_want, nx_dir;

    function automatic logic [IDX_W-1:0] to_idx(input logic [RC_W-1:0] r, input logic [RC_W-1:0] c);
        return IDX_W'(32'(r) * 32'(COLS) + 32'(c));
    endfunction

    step_ticker #(.STEP_TICKS(STEP_TICKS)) u_ticker (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    always_comb begin
        dir_in = NONE;
        if (up)         dir_in = UP;
        else if (down)  dir_in = DOWN;
        else if (left)  dir_in = LEFT;
        else if (right) dir_in = RIGHT;
    end

    assign nx_want = next_rowcol(row_q, col_q, want_dir, COLS, ROWS, WRAP_EN != 0);
    assign nx_dir  = next_rowcol(row_q, col_q, dir, COLS, ROWS, WRAP_EN != 0);

    // A failed turn attempt either retries along the heading or ends the attempt.
    assign try_fail  = ((state == ST_REQ_W) && tgt_off) ||
                       ((state == ST_WAIT_W) && wall.wall_valid && wall.wall_is_wall);
    assign take_move = ((state == ST_WAIT_W) || (state == ST_WAIT_C)) &&
                       wall.wall_valid && !wall.wall_is_wall;

    assign wall.wall_req  = ((state == ST_REQ_W) || (state == ST_REQ_C)) && !tgt_off;
    assign wall.wall_addr = addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            row_q      <= START_ROW;
            col_q      <= START_COL;
            curr_block <= IDX_W'(START_IDX);
            dir        <= NONE;
            want_dir   <= NONE;
            snap       <= NONE;
            tgt_row    <= '0;
            tgt_col    <= '0;
            tgt_off    <= 1'b0;
            addr_q     <= '0;
            moved      <= 1'b0;
            blocked    <= 1'b0;
        end else begin
            moved   <= 1'b0;
            blocked <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick && (want_dir != NONE)) begin
                        snap    <= want_dir;
                        tgt_row <= nx_want.row;
                        tgt_col <= nx_want.col;
                        tgt_off <= nx_want.off;
                        addr_q  <= to_idx(nx_want.row, nx_want.col);
                        state   <= ST_REQ_W;
                    end else if (tick && (dir != NONE)) begin
                        tgt_row <= nx_dir.row;
                        tgt_col <= nx_dir.col;
                        tgt_off <= nx_dir.off;
                        addr_q  <= to_idx(nx_dir.row, nx_dir.col);
                        state   <= ST_REQ_C;
                    end
                end
                ST_REQ_W: if (!tgt_off) state <= ST_WAIT_W;
                ST_WAIT_W: begin
                    if (take_move) begin
                        dir      <= snap;
                        want_dir <= NONE;
                        state    <= ST_IDLE;
                    end
                end
                ST_REQ_C: begin
                    if (tgt_off) begin
                        dir     <= NONE;
                        blocked <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT_C;
                    end
                end
                ST_WAIT_C: begin
                    if (wall.wall_valid) begin
                        if (wall.wall_is_wall) begin
                            dir     <= NONE;
                            blocked <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (take_move) begin
                row_q      <= tgt_row;
                col_q      <= tgt_col;
                curr_block <= addr_q;
                moved      <= 1'b1;
            end

            if (try_fail) begin
                if ((dir != NONE) && (dir != snap)) begin
                    tgt_row <= nx_dir.row;
                    tgt_col <= nx_dir.col;
                    tgt_off <= nx_dir.off;
                    addr_q  <= to_idx(nx_dir.row, nx_dir.col);
                    state   <= ST_REQ_C;
                end else begin
                    blocked <= 1'b1;
                    dir     <= NONE;
                    state   <= ST_IDLE;
                end
            end

            // Fresh input overrides the clear on a successful turn in the same cycle.
            if (dir_in != NONE) want_dir <= dir_in;
        end
    end
endmodule

// File: tb/tb_grid_mover.sv
module tb_grid_mover;
    localparam int D_NONE  = 0;
    localparam int D_UP    = 1;
    localparam int D_RIGHT = 4;
    localparam int K_REQ   = 0;
    localparam int K_MOV   = 1;
    localparam int K_BLK   = 2;

    typedef struct {
        int id;
        int kind;
        int val;
        int d;
        int gap;
    } ev_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       enable = 1'b1;
    logic [3:0] btn    [4];
    logic       wreq   [4];
    logic [9:0] waddr  [4];
    logic [9:0] cb     [4];
    logic [2:0] dir_o  [4];
    logic       mv     [4];
    logic       blk    [4];

    bit mem_en = 1'b1;
    bit inj    = 1'b0;
    bit wall_map [4][1024];

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  nreq [4];
    int  nmv [4];
    int  last_req [4];
    int  last_mv [4];
    ev_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT 0: default maze; 1: wrap at east edge; 2: no wrap at east edge; 3: top row.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        grid_mover_if #(.IDX_W(10)) wif ();

        grid_mover #(
            .START_IDX ((g == 0) ? 658 : (g == 3) ? 5 : 419),
            .WRAP_EN   ((g == 2) ? 0 : 1)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .enable     (enable),
            .up         (btn[g][3]),
            .down       (btn[g][2]),
            .left       (btn[g][1]),
            .right      (btn[g][0]),
            .wall       (wif),
            .curr_block (cb[g]),
            .dir        (dir_o[g]),
            .moved      (mv[g]),
            .blocked    (blk[g])
        );

        assign wreq[g]  = wif.wall_req;
        assign waddr[g] = wif.wall_addr;

        always @(posedge clk) begin
            wif.wall_valid   <= (mem_en && wif.wall_req) || ((g == 0) && inj);
            wif.wall_is_wall <= ((g == 0) && inj) ? 1'b0 : wall_map[g][wif.wall_addr];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int id, input int kind, input int val, input int d, input int gap);
        ev_t e;
        e.id = id; e.kind = kind; e.val = val; e.d = d; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic score(input int g, input int kind, input int val, input int d, output int gap);
        ev_t e;
        checks++;
        gap = 0;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event dut=%0d kind=%0d actual=%0d dir=%0d required=none", g, kind, val, d);
        end else begin
            e = exp_q.pop_front();
            gap = e.gap;
            if (e.id != g || e.kind != kind || e.val != val || (kind != K_REQ && e.d != d)) begin
                failures++;
                $display("FAIL event actual(dut=%0d kind=%0d val=%0d dir=%0d) required(dut=%0d kind=%0d val=%0d dir=%0d)",
                         g, kind, val, d, e.id, e.kind, e.val, e.d);
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        int gp;
        for (int g = 0; g < 4; g++) begin
            if (wreq[g]) begin
                nreq[g]++;
                last_req[g] = cyc;
                score(g, K_REQ, int'(waddr[g]), 0, gp);
            end
            if (mv[g]) begin
                nmv[g]++;
                score(g, K_MOV, int'(cb[g]), int'(dir_o[g]), gp);
                chk("move_latency", cyc - last_req[g], 2);
                if (gp != 0) chk("step_spacing", cyc - last_mv[g], gp);
                last_mv[g] = cyc;
            end
            if (blk[g]) score(g, K_BLK, int'(cb[g]), int'(dir_o[g]), gp);
            if (mv[g] || blk[g]) chk("moved_blocked_excl", int'(mv[g] && blk[g]), 0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int g, input logic [3:0] b);
        @(negedge clk);
        btn[g] = b;
        @(negedge clk);
        btn[g] = 4'b0000;
    endtask

    task automatic wait_empty(input int limit);
        int i = 0;
        while (i < limit && exp_q.size() != 0) begin
            @(posedge clk);
            i++;
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        cycles(2);
        reset = 1'b1;
    endtask

    initial begin
        int n0;
        int k;
        for (int g = 0; g < 4; g++) begin
            btn[g] = 4'b0000;
            nreq[g] = 0; nmv[g] = 0; last_req[g] = 0; last_mv[g] = 0;
        end
        wall_map[0][632] = 1'b1;
        wall_map[0][605] = 1'b1;
        wall_map[0][662] = 1'b1;
        wall_map[1][393] = 1'b1;

        // Reset state and idle behaviour.
        cycles(3);
        chk("rst_curr_block", int'(cb[0]), 658);
        chk("rst_dir", int'(dir_o[0]), D_NONE);
        chk("rst_wall_req", int'(wreq[0]), 0);
        chk("rst_moved", int'(mv[0]), 0);
        chk("rst_curr_block_419", int'(cb[1]), 419);
        chk("rst_curr_block_5", int'(cb[3]), 5);
        reset = 1'b1;
        n0 = nreq[0];
        cycles(40);
        chk("idle_no_req", nreq[0] - n0, 0);

        // Straight moves, then a buffered turn that first falls back, then a wall ahead.
        push(0, K_REQ, 659, 0, 0);
        push(0, K_MOV, 659, D_RIGHT, 0);
        push(0, K_REQ, 660, 0, 0);
        push(0, K_MOV, 660, D_RIGHT, 4);
        push(0, K_REQ, 632, 0, 0);
        push(0, K_REQ, 661, 0, 0);
        push(0, K_MOV, 661, D_RIGHT, 0);
        push(0, K_REQ, 633, 0, 0);
        push(0, K_MOV, 633, D_UP, 0);
        push(0, K_REQ, 605, 0, 0);
        push(0, K_BLK, 633, D_NONE, 0);
        press(0, 4'b0001);
        k = 0;
        while (k < 100 && !(mv[0] && cb[0] == 10'd660)) begin
            @(negedge clk);
            k++;
        end
        chk("reached_660", int'(k < 100), 1);
        btn[0] = 4'b1000;
        @(negedge clk);
        btn[0] = 4'b0000;
        wait_empty(200);
        chk("turn_curr_block", int'(cb[0]), 633);
        chk("turn_dir_after_block", int'(dir_o[0]), D_NONE);

        // Run into a wall while heading right.
        pulse_reset();
        push(0, K_REQ, 659, 0, 0);
        push(0, K_MOV, 659, D_RIGHT, 0);
        push(0, K_REQ, 660, 0, 0);
        push(0, K_MOV, 660, D_RIGHT, 4);
        push(0, K_REQ, 661, 0, 0);
        push(0, K_MOV, 661, D_RIGHT, 4);
        push(0, K_REQ, 662, 0, 0);
        push(0, K_BLK, 661, D_NONE, 0);
        press(0, 4'b0001);
        wait_empty(200);
        n0 = nreq[0];
        cycles(20);
        chk("blocked_no_req", nreq[0] - n0, 0);
        chk("blocked_curr_block", int'(cb[0]), 661);
        chk("blocked_dir", int'(dir_o[0]), D_NONE);

        // Reset while a lookup is outstanding; a late response must be ignored.
        mem_en = 1'b0;
        pulse_reset();
        push(0, K_REQ, 659, 0, 0);
        press(0, 4'b0001);
        wait_empty(100);
        n0 = nmv[0];
        pulse_reset();
        @(negedge clk);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        cycles(10);
        chk("midrst_curr_block", int'(cb[0]), 658);
        chk("midrst_no_move", nmv[0] - n0, 0);
        chk("midrst_dir", int'(dir_o[0]), D_NONE);
        mem_en = 1'b1;

        // Grid edges: east wrap, east without wrap, top row.
        push(1, K_REQ, 392, 0, 0);
        push(1, K_MOV, 392, D_RIGHT, 0);
        push(1, K_REQ, 393, 0, 0);
        push(1, K_BLK, 392, D_NONE, 0);
        press(1, 4'b0001);
        wait_empty(200);
        chk("wrap_curr_block", int'(cb[1]), 392);

        push(2, K_BLK, 419, D_NONE, 0);
        press(2, 4'b0001);
        wait_empty(100);
        pulse_reset();
        push(3, K_BLK, 5, D_NONE, 0);
        press(3, 4'b1000);
        wait_empty(100);
        pulse_reset();
        cycles(20);
        chk("nowrap_no_req", nreq[2], 0);
        chk("top_no_req", nreq[3], 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
